// File: rtl/ysyx_220053_ifu.sv
// Instruction fetch unit: one outstanding imem fetch, buffered word offered to decode over valid/ready.
// Latency >= 3 cycles per instruction (REQ, WAIT, HOLD); id_ready low holds the word and stalls fetch.
module ysyx_220053_ifu #(
  parameter int unsigned       ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [31:0]       imem_resp_data,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [31:0]       id_instr,
  output logic [ADDR_W-1:0] id_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              halted,
  output logic [31:0]       fetch_cnt
);

  typedef enum logic [1:0] {REQ, WAIT, HOLD, HALTED} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] id_pc_q, id_pc_d;
  logic [31:0]       instr_q, instr_d;
  logic [31:0]       cnt_q, cnt_d;
  logic              drop_q, drop_d;
  logic              hpend_q, hpend_d;
  logic [ADDR_W-1:0] target;
  logic              req_fire;
  logic              unused_redirect_lsb;

  // Targets are word aligned; the low bits are ignored.
  assign target              = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign unused_redirect_lsb = ^redirect_pc[1:0];
  assign req_fire            = (state_q == REQ) && imem_req_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= REQ;
      pc_q    <= RESET_PC;
      id_pc_q <= '0;
      instr_q <= '0;
      cnt_q   <= '0;
      drop_q  <= 1'b0;
      hpend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      id_pc_q <= id_pc_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
      hpend_q <= hpend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    id_pc_d = id_pc_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    drop_d  = drop_q;
    hpend_d = hpend_q;
    unique case (state_q)
      REQ: begin
        if (req_fire) begin
          state_d = WAIT;
          // An accepted request must still complete; mark its response for discard.
          if (halt) begin
            drop_d  = 1'b1;
            hpend_d = 1'b1;
          end else if (redirect_valid) begin
            pc_d   = target;
            drop_d = 1'b1;
          end
        end else if (halt) begin
          state_d = HALTED;
        end else if (redirect_valid) begin
          pc_d = target;
        end
      end
      WAIT: begin
        if (imem_resp_valid) begin
          drop_d = 1'b0;
          if (halt || hpend_q) begin
            state_d = HALTED;
          end else if (redirect_valid || drop_q) begin
            state_d = REQ;
            if (redirect_valid) pc_d = target;
          end else begin
            state_d = HOLD;
            instr_d = imem_resp_data;
            id_pc_d = pc_q;
          end
        end else if (halt) begin
          drop_d  = 1'b1;
          hpend_d = 1'b1;
        end else if (redirect_valid) begin
          pc_d   = target;
          drop_d = 1'b1;
        end
      end
      HOLD: begin
        // Halt beats redirect, and redirect beats a same-cycle handoff.
        if (halt) begin
          state_d = HALTED;
        end else if (redirect_valid) begin
          state_d = REQ;
          pc_d    = target;
        end else if (id_ready) begin
          state_d = REQ;
          pc_d    = pc_q + ADDR_W'(4);
          cnt_d   = cnt_q + 32'd1;
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
    endcase
  end

  assign imem_req_valid = (state_q == REQ) && !rst;
  assign imem_req_addr  = pc_q;
  assign id_valid       = (state_q == HOLD);
  assign id_instr       = instr_q;
  assign id_pc          = id_pc_q;
  assign halted         = (state_q == HALTED);
  assign fetch_cnt      = cnt_q;

endmodule

// File: tb/tb_ysyx_220053_ifu.sv
// Directed bench for ysyx_220053_ifu with a small latency-programmable instruction memory model.
module tb_ysyx_220053_ifu;

  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [63:0] id_pc;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        halt;
  logic        halted;
  logic [31:0] fetch_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int mem_lat  = 1;

  ysyx_220053_ifu dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .halted         (halted),
    .fetch_cnt      (fetch_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == RST_PC) return 32'h0010_0093;
    return a[31:0] ^ 32'hA5A5_0013;
  endfunction

  // Memory model: evaluates just after each falling edge, response sampled mem_lat rising edges after acceptance.
  initial begin
    bit          pend;
    int          rem;
    logic [63:0] paddr;
    pend = 1'b0;
    rem = 0;
    paddr = '0;
    imem_resp_valid = 1'b0;
    imem_resp_data = '0;
    forever begin
      @(negedge clk);
      #1;
      imem_resp_valid = 1'b0;
      if (rst) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          rem--;
          if (rem == 0) begin
            imem_resp_valid = 1'b1;
            imem_resp_data = mem_word(paddr);
            pend = 1'b0;
          end
        end
        if (imem_req_valid && imem_req_ready) begin
          pend = 1'b1;
          rem = mem_lat;
          paddr = imem_req_addr;
        end
      end
    end
  end

  task automatic wait_id(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (id_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    imem_req_ready = 1'b0;
    id_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    halt = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_req_valid: got %0b want 0", imem_req_valid); end
    n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL rst_id_valid: got %0b want 0", id_valid); end
    n_checks++; if (id_instr !== 32'h0) begin n_fail++; $display("FAIL rst_id_instr: got %h want 0", id_instr); end
    n_checks++; if (id_pc !== 64'h0) begin n_fail++; $display("FAIL rst_id_pc: got %h want 0", id_pc); end
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL rst_halted: got %0b want 0", halted); end
    n_checks++; if (fetch_cnt !== 32'h0) begin n_fail++; $display("FAIL rst_fetch_cnt: got %h want 0", fetch_cnt); end
  endtask

  task automatic test_basic;
    rst = 1'b0;
    imem_req_ready = 1'b1;
    id_ready = 1'b1;
    mem_lat = 1;
    #1;
    n_checks++; if (imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL basic_req_valid: got %0b want 1", imem_req_valid); end
    n_checks++; if (imem_req_addr !== RST_PC) begin n_fail++; $display("FAIL basic_req_addr: got %h want %h", imem_req_addr, RST_PC); end
    @(negedge clk);
    n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL basic_wait_req: got %0b want 0", imem_req_valid); end
    @(negedge clk);
    n_checks++; if (id_valid !== 1'b1) begin n_fail++; $display("FAIL basic_id_valid: got %0b want 1", id_valid); end
    n_checks++; if (id_instr !== 32'h0010_0093) begin n_fail++; $display("FAIL basic_id_instr: got %h want 00100093", id_instr); end
    n_checks++; if (id_pc !== RST_PC) begin n_fail++; $display("FAIL basic_id_pc: got %h want %h", id_pc, RST_PC); end
    @(negedge clk);
    n_checks++; if (fetch_cnt !== 32'd1) begin n_fail++; $display("FAIL basic_fetch_cnt: got %0d want 1", fetch_cnt); end
    n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL basic_id_drop: got %0b want 0", id_valid); end
    n_checks++; if (imem_req_addr !== 64'h8000_0004) begin n_fail++; $display("FAIL basic_next_addr: got %h want 80000004", imem_req_addr); end
    id_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    bit ok;
    wait_id(10, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_timeout: id_valid low for 10 cycles, want high"); end
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (id_instr !== mem_word(64'h8000_0004)) begin n_fail++; $display("FAIL bp_instr[%0d]: got %h want %h", i, id_instr, mem_word(64'h8000_0004)); end
      n_checks++; if (id_pc !== 64'h8000_0004) begin n_fail++; $display("FAIL bp_pc[%0d]: got %h want 80000004", i, id_pc); end
      n_checks++; if (imem_req_valid !== 1'b0 || id_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valids[%0d]: got req=%0b id=%0b want 0/1", i, imem_req_valid, id_valid); end
      n_checks++; if (fetch_cnt !== 32'd1) begin n_fail++; $display("FAIL bp_cnt[%0d]: got %0d want 1", i, fetch_cnt); end
      @(negedge clk);
    end
    id_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (fetch_cnt !== 32'd2) begin n_fail++; $display("FAIL bp_fire_cnt: got %0d want 2", fetch_cnt); end
    n_checks++; if (imem_req_addr !== 64'h8000_0008) begin n_fail++; $display("FAIL bp_next_addr: got %h want 80000008", imem_req_addr); end
    id_ready = 1'b0;
  endtask

  task automatic test_redirect_wait;
    bit seen_id;
    bit got_req;
    bit ok;
    mem_lat = 3;
    @(negedge clk);
    n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rw_in_wait: got req=%0b want 0", imem_req_valid); end
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_0100;
    @(negedge clk);
    redirect_valid = 1'b0;
    seen_id = 1'b0;
    got_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      seen_id |= id_valid;
      if (imem_req_valid) begin
        got_req = 1'b1;
        break;
      end
      @(negedge clk);
    end
    mem_lat = 1;
    n_checks++; if (!got_req) begin n_fail++; $display("FAIL rw_req_timeout: no request within 10 cycles"); end
    n_checks++; if (seen_id !== 1'b0) begin n_fail++; $display("FAIL rw_stale_presented: got id_valid=1 want 0"); end
    n_checks++; if (imem_req_addr !== 64'h8000_0100) begin n_fail++; $display("FAIL rw_addr: got %h want 80000100", imem_req_addr); end
    wait_id(10, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rw_id_timeout: id_valid low for 10 cycles"); end
    n_checks++; if (id_pc !== 64'h8000_0100) begin n_fail++; $display("FAIL rw_id_pc: got %h want 80000100", id_pc); end
    n_checks++; if (id_instr !== mem_word(64'h8000_0100)) begin n_fail++; $display("FAIL rw_id_instr: got %h want %h", id_instr, mem_word(64'h8000_0100)); end
  endtask

  task automatic test_redirect_hold;
    id_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_0102;
    @(negedge clk);
    n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL rh_id_valid: got %0b want 0", id_valid); end
    n_checks++; if (fetch_cnt !== 32'd2) begin n_fail++; $display("FAIL rh_cnt: got %0d want 2", fetch_cnt); end
    n_checks++; if (imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL rh_req_valid: got %0b want 1", imem_req_valid); end
    n_checks++; if (imem_req_addr !== 64'h8000_0100) begin n_fail++; $display("FAIL rh_addr: got %h want 80000100", imem_req_addr); end
    redirect_valid = 1'b0;
    id_ready = 1'b0;
    imem_req_ready = 1'b0;
  endtask

  task automatic test_req_stall;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0100) begin n_fail++; $display("FAIL stall_hold[%0d]: got v=%0b a=%h want 1/80000100", i, imem_req_valid, imem_req_addr); end
    end
    redirect_valid = 1'b1;
    redirect_pc = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    n_checks++; if (imem_req_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_fail++; $display("FAIL stall_redirect: got %h want fffffffffffffffc", imem_req_addr); end
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
  endtask

  task automatic test_pc_wrap;
    bit ok;
    wait_id(10, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL pcw_timeout: id_valid low for 10 cycles"); end
    n_checks++; if (id_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_fail++; $display("FAIL pcw_id_pc: got %h want fffffffffffffffc", id_pc); end
    n_checks++; if (id_instr !== mem_word(64'hFFFF_FFFF_FFFF_FFFC)) begin n_fail++; $display("FAIL pcw_instr: got %h want %h", id_instr, mem_word(64'hFFFF_FFFF_FFFF_FFFC)); end
    id_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (imem_req_addr !== 64'h0) begin n_fail++; $display("FAIL pcw_addr: got %h want 0", imem_req_addr); end
    n_checks++; if (fetch_cnt !== 32'd3) begin n_fail++; $display("FAIL pcw_cnt: got %0d want 3", fetch_cnt); end
    id_ready = 1'b0;
  endtask

  task automatic test_cnt_wrap;
    bit ok;
    wait_id(10, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL cw_timeout: id_valid low for 10 cycles"); end
    n_checks++; if (id_pc !== 64'h0) begin n_fail++; $display("FAIL cw_id_pc: got %h want 0", id_pc); end
    dut.cnt_q = 32'hFFFF_FFFF;
    id_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (fetch_cnt !== 32'h0) begin n_fail++; $display("FAIL cw_wrap: got %h want 0", fetch_cnt); end
    n_checks++; if (imem_req_addr !== 64'h4) begin n_fail++; $display("FAIL cw_addr: got %h want 4", imem_req_addr); end
    id_ready = 1'b0;
  endtask

  task automatic test_halt;
    bit seen_req;
    bit seen_id;
    mem_lat = 3;
    @(negedge clk);
    n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL halt_in_wait: got req=%0b want 0", imem_req_valid); end
    halt = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_0400;
    @(negedge clk);
    redirect_valid = 1'b0;
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL halt_early: got halted=%0b want 0", halted); end
    seen_req = 1'b0;
    seen_id = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      seen_req |= imem_req_valid;
      seen_id |= id_valid;
    end
    n_checks++; if (seen_req !== 1'b0) begin n_fail++; $display("FAIL halt_req_seen: got 1 want 0"); end
    n_checks++; if (seen_id !== 1'b0) begin n_fail++; $display("FAIL halt_id_seen: got 1 want 0"); end
    n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_halted: got %0b want 1", halted); end
    n_checks++; if (fetch_cnt !== 32'h0) begin n_fail++; $display("FAIL halt_cnt: got %h want 0", fetch_cnt); end
  endtask

  task automatic test_reset_mid_wait;
    bit ok;
    halt = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL rmw_halted: got %0b want 0", halted); end
    @(negedge clk);
    rst = 1'b0;
    mem_lat = 5;
    #1;
    n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin n_fail++; $display("FAIL rmw_first_req: got v=%0b a=%h want 1/%h", imem_req_valid, imem_req_addr, RST_PC); end
    @(negedge clk);
    n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rmw_wait: got %0b want 0", imem_req_valid); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rmw_async_req: got %0b want 0", imem_req_valid); end
    @(negedge clk);
    rst = 1'b0;
    mem_lat = 1;
    id_ready = 1'b1;
    #1;
    n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin n_fail++; $display("FAIL rmw_restart: got v=%0b a=%h want 1/%h", imem_req_valid, imem_req_addr, RST_PC); end
    wait_id(10, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rmw_timeout: id_valid low for 10 cycles"); end
    n_checks++; if (id_pc !== RST_PC || id_instr !== 32'h0010_0093) begin n_fail++; $display("FAIL rmw_id: got pc=%h instr=%h want %h/00100093", id_pc, id_instr, RST_PC); end
    @(negedge clk);
    n_checks++; if (fetch_cnt !== 32'd1) begin n_fail++; $display("FAIL rmw_cnt: got %0d want 1", fetch_cnt); end
  endtask

  task automatic test_async_reset_clears;
    id_ready = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++; if (id_instr !== 32'h0 || id_pc !== 64'h0) begin n_fail++; $display("FAIL arst_id: got instr=%h pc=%h want 0/0", id_instr, id_pc); end
    n_checks++; if (fetch_cnt !== 32'h0) begin n_fail++; $display("FAIL arst_cnt: got %h want 0", fetch_cnt); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    test_reset;
    test_basic;
    test_backpressure;
    test_redirect_wait;
    test_redirect_hold;
    test_req_stall;
    test_pc_wrap;
    test_cnt_wrap;
    test_halt;
    test_reset_mid_wait;
    test_async_reset_clears;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
